// File: rtl/aes_sbox_pkg.sv
// rtl/aes_sbox_pkg.sv - AES forward/inverse S-box tables and byte lookup helpers
package aes_sbox_pkg;

  localparam int AES_BYTE_W = 8;

  localparam logic [7:0] SBOX_FWD [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] SBOX_INV [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  function automatic logic [AES_BYTE_W-1:0] sbox_fwd(input logic [AES_BYTE_W-1:0] b);
    return SBOX_FWD[b];
  endfunction

  function automatic logic [AES_BYTE_W-1:0] sbox_inv(input logic [AES_BYTE_W-1:0] b);
    return SBOX_INV[b];
  endfunction

endpackage

// File: rtl/sbox_lane.sv
// rtl/sbox_lane.sv - single-byte combinational S-box lookup
// Forward table only present when SUB_BYTES_FWD_EN is defined.
module sbox_lane
  import aes_sbox_pkg::*;
(
  input  logic [AES_BYTE_W-1:0] i_byte,
  input  logic                  i_inv,
  output logic [AES_BYTE_W-1:0] o_byte
);

`ifdef SUB_BYTES_FWD_EN
  assign o_byte = i_inv ? sbox_inv(i_byte) : sbox_fwd(i_byte);
`else
  logic w_unused_inv;
  assign w_unused_inv = i_inv;
  assign o_byte       = sbox_inv(i_byte);
`endif

endmodule

// File: rtl/sub_bytes_pipe.sv
// rtl/sub_bytes_pipe.sv - 2-stage valid/ready AES SubBytes/InvSubBytes engine
// Define SUB_BYTES_FWD_EN to build the forward table and honour in_inv per beat.
module sub_bytes_pipe
  import aes_sbox_pkg::*;
#(
  parameter  int LANES = 16,
  localparam int DW    = AES_BYTE_W * LANES
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_inv,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_inv,
  output logic          busy
);

  logic          r_s1_valid;
  logic [DW-1:0] r_s1_data;
  logic          r_s2_valid;
  logic [DW-1:0] r_s2_data;
  logic [DW-1:0] w_lut;
  logic          w_s1_inv;
  logic          w_s1_adv;
  logic          w_s2_adv;

  assign w_s2_adv = !r_s2_valid || out_ready;
  assign w_s1_adv = !r_s1_valid || w_s2_adv;
  assign in_ready = w_s1_adv;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
    end else begin
      if (w_s1_adv) r_s1_valid <= in_valid;
      if (w_s2_adv) r_s2_valid <= r_s1_valid;
    end
  end

  // Payload only loads on a real transfer, so a stalled stage keeps its bytes.
  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) r_s1_data <= in_data;
    if (w_s2_adv && r_s1_valid) r_s2_data <= w_lut;
  end

`ifdef SUB_BYTES_FWD_EN
  logic r_s1_inv;
  logic r_s2_inv;

  always_ff @(posedge clk) begin
    if (w_s1_adv && in_valid) r_s1_inv <= in_inv;
    if (w_s2_adv && r_s1_valid) r_s2_inv <= r_s1_inv;
  end

  assign w_s1_inv = r_s1_inv;
  assign out_inv  = r_s2_valid & r_s2_inv;
`else
  logic w_unused_in_inv;
  assign w_unused_in_inv = in_inv;
  assign w_s1_inv        = 1'b1;
  assign out_inv         = r_s2_valid;
`endif

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    sbox_lane u_lane (
      .i_byte (r_s1_data[AES_BYTE_W*g +: AES_BYTE_W]),
      .i_inv  (w_s1_inv),
      .o_byte (w_lut[AES_BYTE_W*g +: AES_BYTE_W])
    );
  end

  assign out_valid = r_s2_valid;
  assign out_data  = r_s2_valid ? r_s2_data : '0;
  assign busy      = r_s1_valid | r_s2_valid;

endmodule

// File: tb/tb_sub_bytes_pipe.sv
// tb/tb_sub_bytes_pipe.sv - directed self-checking bench for sub_bytes_pipe
// Exercises the SUB_BYTES_FWD_EN build when that macro is defined.
module tb_sub_bytes_pipe;
  import aes_sbox_pkg::*;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, in_inv;
  logic [127:0] in_data;
  logic         out_valid, out_ready, out_inv, busy;
  logic [127:0] out_data;

  logic         d4_in_valid, d4_in_ready, d4_in_inv;
  logic [31:0]  d4_in_data;
  logic         d4_out_valid, d4_out_ready, d4_out_inv, d4_busy;
  logic [31:0]  d4_out_data;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  sub_bytes_pipe #(.LANES(16)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_inv(in_inv), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inv(out_inv), .busy(busy)
  );

  sub_bytes_pipe #(.LANES(4)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(d4_in_valid), .in_ready(d4_in_ready), .in_data(d4_in_data),
    .in_inv(d4_in_inv), .out_valid(d4_out_valid), .out_ready(d4_out_ready), .out_data(d4_out_data),
    .out_inv(d4_out_inv), .busy(d4_busy)
  );

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [7:0] t3_in  [8] = '{8'h00, 8'h01, 8'h63, 8'h7c, 8'hff, 8'h09, 8'h52, 8'h53};
  logic [7:0] t3_exp [8] = '{8'h52, 8'h09, 8'h00, 8'h01, 8'h7d, 8'h40, 8'h48, 8'h50};
  logic       t3_rdy [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  initial begin
    int sent, rcv, saw_full, stale;
    logic m_s1, m_s2, hold, m_s2_adv, m_s1_adv, acc_in;
    logic [127:0] held;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
    d4_in_valid = 1'b0; d4_in_data = '0; d4_in_inv = 1'b0; d4_out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_inv", out_inv, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);

    // Inverse beat, no backpressure
    out_ready = 1'b1; in_valid = 1'b1; in_inv = 1'b1;
    in_data = 128'h00000000_00000000_000000ff_7c630100;
    tick();
    in_valid = 1'b0;
    check("t1_busy_s1", busy, 1);
    check("t1_early_valid", out_valid, 0);
    tick();
    check("t1_valid", out_valid, 1);
    check("t1_data", out_data, 128'h52525252_52525252_5252527d_01000952);
    check("t1_inv", out_inv, 1);
    check("t1_busy_s2", busy, 1);
    tick();
    check("t1_drained_valid", out_valid, 0);
    check("t1_drained_busy", busy, 0);
    check("t1_drained_data", out_data, 0);

`ifdef SUB_BYTES_FWD_EN
    // Forward then inverse back-to-back
    in_valid = 1'b1; in_inv = 1'b0; in_data = 128'h00000000_00000000_00000000_00525300;
    tick();
    in_inv = 1'b1; in_data = 128'h63636363_63636363_63636363_6300ed63;
    tick();
    in_valid = 1'b0;
    check("t2_fwd_data", out_data, 128'h63636363_63636363_63636363_6300ed63);
    check("t2_fwd_inv", out_inv, 0);
    tick();
    check("t2_inv_data", out_data, 128'h00000000_00000000_00000000_00525300);
    check("t2_inv_inv", out_inv, 1);
    tick();
`else
    // Inverse-only build ignores in_inv
    in_valid = 1'b1; in_inv = 1'b0; in_data = '0;
    tick();
    in_valid = 1'b0;
    tick();
    check("t6_data", out_data, {16{8'h52}});
    check("t6_inv", out_inv, 1);
    tick();
`endif

    // Streaming with out_ready pattern 1,0,0,1
    sent = 0; rcv = 0; saw_full = 0; hold = 1'b0; held = '0; m_s1 = 1'b0; m_s2 = 1'b0;
    for (int cyc = 0; cyc < 100 && rcv < 8; cyc++) begin
      out_ready = t3_rdy[cyc % 4];
      in_valid  = (sent < 8);
      in_inv    = 1'b1;
      in_data   = {16{t3_in[sent % 8]}};
      #1;
      check("t3_in_ready", in_ready, !(m_s1 && m_s2 && !out_ready));
      if (!in_ready) saw_full++;
      if (hold) begin
        check("t3_hold_valid", out_valid, 1);
        check("t3_hold_data", out_data, held);
      end
      acc_in = in_valid && in_ready;
      if (out_valid && out_ready) begin
        check("t3_order", out_data, {16{t3_exp[rcv % 8]}});
        rcv++;
      end
      hold = out_valid && !out_ready;
      held = out_data;
      if (acc_in) sent++;
      m_s2_adv = !m_s2 || out_ready;
      m_s1_adv = !m_s1 || m_s2_adv;
      if (m_s2_adv) m_s2 = m_s1;
      if (m_s1_adv) m_s1 = in_valid;
      tick();
    end
    in_valid = 1'b0;
    check("t3_count", rcv, 8);
    check("t3_saw_full", saw_full > 0, 1);
    out_ready = 1'b1;
    repeat (3) tick();

    // Reset with two beats in flight
    out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b1; in_data = {16{8'h01}};
    tick();
    in_data = {16{8'h63}};
    tick();
    in_valid = 1'b0;
    check("t4_busy_full", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    check("t4_out_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_in_ready", in_ready, 1);
    out_ready = 1'b1;
    stale = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (out_valid) stale++;
    end
    check("t4_no_stale", stale, 0);

    // Four-lane key-schedule word
    d4_in_valid = 1'b1; d4_in_inv = 1'b1; d4_in_data = 32'h00635209;
    tick();
    d4_in_valid = 1'b0;
    tick();
    check("t5_valid", d4_out_valid, 1);
    check("t5_data", {96'h0, d4_out_data}, 128'h52004840);
    tick();
    check("t5_drained", d4_busy, 0);

    for (int x = 0; x < 256; x++) begin
      logic [7:0] xb;
      xb = 8'(x);
      check("t5_roundtrip", sbox_fwd(sbox_inv(xb)), xb);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
